// File: rtl/hex_display_serial_base10.sv
// hex_display_serial_base10: serial double-dabble driver for six active-low 7-segment digits.
// Define HEX_DISPLAY_SIGNED_EN to treat value_in as two's complement with a minus sign on HEX5.
module hex_display_serial_base10 #(
  parameter int REFRESH_CYCLES      = 4500000,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic        main_clk,
  input  logic        reset_n,
  input  logic [15:0] value_in,
  input  logic        update_req,
  output logic        busy,
  output logic        done_pulse,
  output logic [47:0] hex_out
);
  localparam int CW = $clog2(REFRESH_CYCLES);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    state_q, state_d;
  logic          pending_q, pending_d, busy_q, busy_d, done_q, done_d;
  logic [15:0]   op_q, op_d, mag;
  logic [19:0]   bcd_q, bcd_d, adj;
  logic [3:0]    bit_q, bit_d;
  logic [47:0]   hex_q, hex_d;
  logic [39:0]   enc;
  logic [35:0]   sh;
  logic [7:0]    hex5;
  logic          tick, trig, start, z;

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

`ifdef HEX_DISPLAY_SIGNED_EN
  logic sign_q, sign_d;
  // 16'h8000 negates to itself, which reads correctly as unsigned 32768
  assign mag    = value_in[15] ? 16'(-value_in) : value_in;
  assign sign_d = start ? value_in[15] : sign_q;
  assign hex5   = sign_q ? 8'hBF : 8'hFF;
  always_ff @(posedge main_clk or negedge reset_n)
    if (!reset_n) sign_q <= 1'b0;
    else sign_q <= sign_d;
`else
  assign mag  = value_in;
  assign hex5 = 8'hFF;
`endif

  always_comb begin
    tick      = cnt_q == CW'(REFRESH_CYCLES - 1);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    trig      = tick | update_req;
    start     = (state_q == IDLE) && (trig || pending_q);
    pending_d = start ? 1'b0 : ((state_q != IDLE) && trig) ? 1'b1 : pending_q;
    adj = '0;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    sh    = {adj, op_q} << 1;
    op_d  = start ? mag : (state_q == SHIFT) ? sh[15:0] : op_q;
    bcd_d = start ? 20'h0 : (state_q == SHIFT) ? sh[35:16] : bcd_q;
    bit_d = start ? 4'd15 : (state_q == SHIFT) ? bit_q - 4'd1 : bit_q;
    state_d = start ? SHIFT :
              (state_q == SHIFT) ? ((bit_q == 4'd0) ? COMMIT : SHIFT) :
              (state_q == COMMIT) ? IDLE : state_q;
    // a digit blanks only while it and every higher digit are zero
    enc = '0;
    z   = 1'b1;
    for (int k = 4; k >= 0; k--) begin
      z = z & (bcd_q[4*k +: 4] == 4'd0);
      enc[8*k +: 8] = (BLANK_LEADING_ZEROS && z && k != 0) ? 8'hFF : seg(bcd_q[4*k +: 4]);
    end
    hex_d  = (state_q == COMMIT) ? {hex5, enc} : hex_q;
    busy_d = start ? 1'b1 : (state_q == COMMIT) ? 1'b0 : busy_q;
    done_d = state_q == COMMIT;
  end

  always_ff @(posedge main_clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q     <= '0;
      state_q   <= IDLE;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      op_q      <= '0;
      bcd_q     <= '0;
      bit_q     <= '0;
      hex_q     <= 48'hFFFF_FFFF_FFFF;
    end else begin
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      op_q      <= op_d;
      bcd_q     <= bcd_d;
      bit_q     <= bit_d;
      hex_q     <= hex_d;
    end

  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign hex_out    = hex_q;
endmodule

// File: tb/tb_hex_display_serial_base10.sv
// tb_hex_display_serial_base10: random and directed checks against a timestamp-level reference model.
module tb_hex_display_serial_base10;
  localparam int R = 32;
  logic        main_clk = 1'b0;
  logic        reset_n  = 1'b0;
  logic [15:0] value_in = '0;
  logic        update_req = 1'b0;
  logic        busy, done_pulse;
  logic [47:0] hex_out;

  hex_display_serial_base10 #(.REFRESH_CYCLES(R), .BLANK_LEADING_ZEROS(1'b1)) dut (
    .main_clk(main_clk), .reset_n(reset_n), .value_in(value_in),
    .update_req(update_req), .busy(busy), .done_pulse(done_pulse), .hex_out(hex_out)
  );

  always #5 main_clk = ~main_clk;

  int n_chk = 0, n_pass = 0;
  int cyc, left;
  bit pend, e_done;
  logic [15:0] mval;
  logic [47:0] e_hex;
  logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [47:0] ref_hex(input logic [15:0] v);
    int m = v, p = 1;
    bit neg = 1'b0;
    logic [47:0] r;
`ifdef HEX_DISPLAY_SIGNED_EN
    neg = v[15];
    if (neg) m = 65536 - int'(v);
`endif
    r[47:40] = neg ? 8'hBF : 8'hFF;
    for (int k = 0; k < 5; k++) begin
      r[8*k +: 8] = (k > 0 && m < p) ? 8'hFF : segtab[(m / p) % 10];
      p *= 10;
    end
    return r;
  endfunction

  task automatic m_reset();
    cyc = 0; left = 0; pend = 0; e_done = 0; e_hex = '1;
  endtask

  // one capture per trigger while idle, 17 edges to the commit, triggers while busy collapse into one
  task automatic model_edge();
    bit trg = ((cyc % R) == R - 1) || update_req;
    e_done = 0;
    if (left == 0) begin
      if (trg || pend) begin mval = value_in; pend = 0; left = 17; end
    end else begin
      if (trg) pend = 1;
      left--;
      if (left == 0) begin e_hex = ref_hex(mval); e_done = 1; end
    end
    cyc++;
  endtask

  task automatic cycle();
    @(posedge main_clk);
    if (reset_n) model_edge();
    @(negedge main_clk);
    chk("hex", hex_out, e_hex);
    chk("busy", 48'(busy), 48'(left != 0));
    chk("done", 48'(done_pulse), 48'(e_done));
  endtask

  task automatic do_reset();
    reset_n = 0; update_req = 0; m_reset();
    repeat (2) @(posedge main_clk);
    @(negedge main_clk);
    reset_n = 1;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n <= 40) begin
      cycle(); n++;
      if (done_pulse) break;
    end
  endtask

  task automatic convert(input string tag, input logic [15:0] v, input logic [47:0] exp);
    int n;
    do_reset();
    value_in = v; update_req = 1;
    cycle();
    update_req = 0;
    wait_done(n);
    chk({tag, "_lat"}, 48'(n + 1), 48'd18);
    chk(tag, hex_out, exp);
  endtask

  initial begin
    int n, dones;
    do_reset();
    repeat (31) begin
      cycle();
      chk("idle_hex", hex_out, 48'hFFFF_FFFF_FFFF);
      chk("idle_busy", 48'(busy), 48'd0);
    end
    do_reset();
    value_in = 16'd12345; update_req = 1;
    cycle();
    update_req = 0;
    chk("busy_rise", 48'(busy), 48'd1);
    wait_done(n);
    chk("lat12345", 48'(n + 1), 48'd18);
    chk("hex12345", hex_out, 48'hFF_F9_A4_B0_99_92);
    convert("zero", 16'd0, 48'hFF_FF_FF_FF_FF_C0);
`ifdef HEX_DISPLAY_SIGNED_EN
    convert("neg8000", 16'h8000, 48'hBF_B0_A4_F8_82_80);
    convert("negone", 16'hFFFF, 48'hBF_FF_FF_FF_FF_F9);
`else
    convert("max", 16'hFFFF, 48'hFF_82_92_92_B0_92);
`endif
    // pending collapse: capture at edge 20, extra requests and the edge-32 tick land in flight
    do_reset();
    value_in = 16'($urandom);
    repeat (19) cycle();
    update_req = 1; cycle(); update_req = 0;
    repeat (4) cycle();
    update_req = 1; cycle(); update_req = 0;
    repeat (2) cycle();
    update_req = 1; cycle(); update_req = 0;
    dones = 0;
    repeat (42) begin
      cycle();
      if (done_pulse) dones++;
    end
    chk("dones", 48'(dones), 48'd2);
    // asynchronous reset in the middle of a conversion
    do_reset();
    value_in = 16'($urandom); update_req = 1;
    cycle();
    update_req = 0;
    repeat (7) cycle();
    reset_n = 0;
    #1;
    chk("rst_hex", hex_out, 48'hFFFF_FFFF_FFFF);
    chk("rst_busy", 48'(busy), 48'd0);
    m_reset();
    repeat (2) cycle();
    reset_n = 1;
    value_in = 16'($urandom); update_req = 1;
    cycle();
    update_req = 0;
    wait_done(n);
    chk("rst_lat", 48'(n + 1), 48'd18);
    chk("rst_val", hex_out, ref_hex(value_in));
    do_reset();
    repeat (400) begin
      value_in = 16'($urandom);
      update_req = ($urandom % 6) == 0;
      cycle();
    end
    update_req = 0;
    repeat (40) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
